// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu (package)
// Description : Shared types and constants for the voxel GPU register bank:
//               vec3/camera types, s1 register word addresses, STATUS bit
//               positions and the default pixel buffer address.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu;

    // Number of look vectors the default camera_t carries.
    localparam int DEFAULT_NUM_LOOK = 4;

    // x occupies the low word so a packed array of vec3_t lines up with the
    // camera words as they appear in the register map (x, y, z per vector).
    typedef struct packed {
        logic [31:0] z;
        logic [31:0] y;
        logic [31:0] x;
    } vec3_t;

    // Bit-identical to "vec3_t [NUM_LOOK:0]" with pos at index 0 and
    // look[j] at index j+1, which is how the bank exports its camera for an
    // arbitrary NUM_LOOK.
    typedef struct packed {
        vec3_t [DEFAULT_NUM_LOOK-1:0] look;
        vec3_t                        pos;
    } camera_t;

    localparam logic [7:0] REG_PIXEL_BUFFER   = 8'h00;
    localparam logic [7:0] REG_VOXEL_BUFFER   = 8'h01;
    localparam logic [7:0] REG_VOXEL_COUNT    = 8'h02;
    localparam logic [7:0] REG_PALETTE_BUFFER = 8'h03;
    localparam logic [7:0] REG_PALETTE_LENGTH = 8'h04;
    localparam logic [7:0] REG_FRAME_COUNT    = 8'h0C;
    localparam logic [7:0] REG_IRQ_ENABLE     = 8'h0D;
    localparam logic [7:0] REG_STATUS         = 8'h0E;
    localparam logic [7:0] REG_CONTROL        = 8'h0F;
    localparam logic [7:0] REG_CAM_BASE       = 8'h10;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_PENDING_BIT = 1;
    localparam int STATUS_IRQ_BIT     = 2;

    localparam logic [31:0] DEFAULT_BUFFER = 32'h0800_0000;

endpackage
`default_nettype wire

// File: rtl/gpu_csr_reg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_csr_reg
// Description : 32-bit software register with per-byte write enables.
// Ports       : clock, reset (sync, active high), wr_en, byteenable[3:0],
//               writedata[31:0] -> value[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_csr_reg #(
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= RESET_VALUE;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    value[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : gpu_csr_bank
// Description : Avalon-MM CSR bank for the voxel GPU. Software programs a
//               shadow bank; a render request copies it into the active bank
//               that drives gpu_controller. Render FSM with a one-deep request
//               queue, maskable W1C interrupt and a frame counter.
// Ports       : clock, reset            - clock, sync active-high reset
//               s1_*                    - Avalon-MM slave (no wait states)
//               irq                     - irq_status & irq_enable
//               render_start/done       - handshake with gpu_controller
//               cfg_*                   - active configuration bank
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_csr_bank
    import gpu::*;
#(
    parameter int          NUM_LOOK             = 4,
    parameter int          ADDR_WIDTH           = 8,
    parameter int          FRAME_CNT_WIDTH      = 16,
    parameter logic [31:0] DEFAULT_PIXEL_BUFFER = gpu::DEFAULT_BUFFER
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s1_address,
    input  logic                  s1_read,
    output logic [31:0]           s1_readdata,
    input  logic                  s1_write,
    input  logic [31:0]           s1_writedata,
    input  logic [3:0]            s1_byteenable,
    output logic                  s1_waitrequest,
    output logic                  irq,
    output logic                  render_start,
    input  logic                  render_done,
    output logic [31:0]           cfg_pixel_buffer,
    output logic [31:0]           cfg_voxel_buffer,
    output logic [31:0]           cfg_voxel_count,
    output logic [31:0]           cfg_palette_buffer,
    output logic [31:0]           cfg_palette_length,
    output gpu::vec3_t [NUM_LOOK:0] cfg_cam
);

    // Shadow word index: 0..4 are the frame registers, 5.. the camera words.
    localparam int c_num_frame = 5;
    localparam int c_num_cam   = 3 * (1 + NUM_LOOK);
    localparam int c_num_words = c_num_frame + c_num_cam;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_pending;
    logic                       w_pending_next;
    logic                       w_snapshot;
    logic                       w_frame_done;
    logic                       r_render_start;
    logic                       r_irq_status;
    logic                       r_irq_enable;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
    logic [31:0]                w_shadow [c_num_words];
    logic [31:0]                r_active [c_num_words];
    logic [c_num_words-1:0]     w_sel;
    logic [31:0]                w_addr;
    logic                       w_any_be;
    logic                       w_ctrl_wr;
    logic                       w_req;
    logic                       w_irq_clr;
    logic                       w_unused;

    // Reads are address-decoded combinationally; the strobe carries no
    // information for this slave.
    assign w_unused       = s1_read;
    assign s1_waitrequest = 1'b0;

    assign w_addr   = 32'(s1_address);
    assign w_any_be = |s1_byteenable;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < c_num_frame; i++) begin
            if (w_addr == 32'(i)) w_sel[i] = 1'b1;
        end
        for (int k = 0; k < c_num_cam; k++) begin
            if (w_addr == 32'(REG_CAM_BASE) + 32'(k)) w_sel[c_num_frame + k] = 1'b1;
        end
    end

    assign w_ctrl_wr = s1_write && w_any_be && (w_addr == 32'(REG_CONTROL));
    assign w_req     = w_ctrl_wr && (s1_writedata != 32'h0);
    assign w_irq_clr = (w_ctrl_wr && (s1_writedata == 32'h0)) ||
                       (s1_write && w_any_be && (w_addr == 32'(REG_STATUS)) &&
                        s1_writedata[STATUS_IRQ_BIT]);

    generate
        for (genvar i = 0; i < c_num_words; i++) begin : g_shadow
            gpu_csr_reg #(
                .RESET_VALUE((i == 0) ? DEFAULT_PIXEL_BUFFER : 32'h0)
            ) u_reg (
                .clock      (clock),
                .reset      (reset),
                .wr_en      (s1_write && w_sel[i]),
                .byteenable (s1_byteenable),
                .writedata  (s1_writedata),
                .value      (w_shadow[i])
            );
        end
    endgenerate

    // Render FSM. A frame completing with a queued (or simultaneous) request
    // chains straight into the next frame without passing through IDLE.
    // gpu_controller never reports done in the cycle it is started, so a
    // chained start cannot follow another start back to back.
    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_snapshot     = 1'b0;
        w_frame_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_snapshot   = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (render_done) begin
                    w_frame_done = 1'b1;
                    if (r_pending || w_req) begin
                        w_snapshot     = 1'b1;
                        w_pending_next = 1'b0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_req) begin
                    w_pending_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_pending      <= 1'b0;
            r_render_start <= 1'b0;
            r_irq_status   <= 1'b0;
            r_irq_enable   <= 1'b0;
            r_frame_count  <= '0;
            for (int i = 0; i < c_num_words; i++) begin
                r_active[i] <= (i == 0) ? DEFAULT_PIXEL_BUFFER : 32'h0;
            end
        end else begin
            r_state        <= w_state_next;
            r_pending      <= w_pending_next;
            r_render_start <= w_snapshot;
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            // Completion outranks a software clear in the same cycle so a
            // freshly finished frame is never lost.
            if (w_frame_done) begin
                r_irq_status <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_status <= 1'b0;
            end
            if (s1_write && s1_byteenable[0] && (w_addr == 32'(REG_IRQ_ENABLE))) begin
                r_irq_enable <= s1_writedata[0];
            end
            // Shadow outputs still hold pre-write values here, so a write in
            // the snapshot cycle lands in the shadow only.
            if (w_snapshot) begin
                for (int i = 0; i < c_num_words; i++) begin
                    r_active[i] <= w_shadow[i];
                end
            end
        end
    end

    always_comb begin
        s1_readdata = 32'h0;
        for (int i = 0; i < c_num_words; i++) begin
            if (w_sel[i]) s1_readdata = w_shadow[i];
        end
        if (w_addr == 32'(REG_FRAME_COUNT)) s1_readdata = 32'(r_frame_count);
        if (w_addr == 32'(REG_IRQ_ENABLE))  s1_readdata = {31'h0, r_irq_enable};
        if (w_addr == 32'(REG_STATUS)) begin
            s1_readdata[STATUS_BUSY_BIT]    = (r_state == ST_BUSY);
            s1_readdata[STATUS_PENDING_BIT] = r_pending;
            s1_readdata[STATUS_IRQ_BIT]     = r_irq_status;
        end
    end

    assign irq                = r_irq_status & r_irq_enable;
    assign render_start       = r_render_start;
    assign cfg_pixel_buffer   = r_active[0];
    assign cfg_voxel_buffer   = r_active[1];
    assign cfg_voxel_count    = r_active[2];
    assign cfg_palette_buffer = r_active[3];
    assign cfg_palette_length = r_active[4];

    generate
        for (genvar k = 0; k <= NUM_LOOK; k++) begin : g_cam
            assign cfg_cam[k].x = r_active[c_num_frame + 3*k];
            assign cfg_cam[k].y = r_active[c_num_frame + 3*k + 1];
            assign cfg_cam[k].z = r_active[c_num_frame + 3*k + 2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpu_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_csr_bank
// Description : Self-checking bench for gpu_csr_bank: directed scenarios
//               followed by randomized s1 traffic, compared every cycle
//               against a register-map level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_csr_bank;
    import gpu::*;

    localparam int NL  = 4;
    localparam int NSH = 5 + 3 * (1 + NL);

    logic        clock;
    logic        reset;
    logic [7:0]  s1_address;
    logic        s1_read;
    logic [31:0] s1_readdata;
    logic        s1_write;
    logic [31:0] s1_writedata;
    logic [3:0]  s1_byteenable;
    logic        s1_waitrequest;
    logic        irq;
    logic        render_start;
    logic        render_done;
    logic [31:0] cfg_pixel_buffer;
    logic [31:0] cfg_voxel_buffer;
    logic [31:0] cfg_voxel_count;
    logic [31:0] cfg_palette_buffer;
    logic [31:0] cfg_palette_length;
    vec3_t [NL:0] cfg_cam;

    gpu_csr_bank #(
        .NUM_LOOK(NL), .ADDR_WIDTH(8), .FRAME_CNT_WIDTH(16),
        .DEFAULT_PIXEL_BUFFER(DEFAULT_BUFFER)
    ) dut (
        .clock(clock), .reset(reset),
        .s1_address(s1_address), .s1_read(s1_read), .s1_readdata(s1_readdata),
        .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_byteenable(s1_byteenable), .s1_waitrequest(s1_waitrequest),
        .irq(irq), .render_start(render_start), .render_done(render_done),
        .cfg_pixel_buffer(cfg_pixel_buffer), .cfg_voxel_buffer(cfg_voxel_buffer),
        .cfg_voxel_count(cfg_voxel_count), .cfg_palette_buffer(cfg_palette_buffer),
        .cfg_palette_length(cfg_palette_length), .cfg_cam(cfg_cam)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model (register-map view) ----------------
    logic [31:0] m_shadow [NSH];
    logic [31:0] m_active [NSH];
    bit          m_busy, m_pending, m_irqs, m_irqen, m_start;
    int unsigned m_fc;

    int n_cmp = 0;
    int n_bad = 0;
    bit prev_start = 1'b0;

    logic [31:0] l_rdata, l_vc, l_vb;
    bit          l_start, l_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_idx(input int addr);
        if (addr >= 0 && addr < 5) return addr;
        if (addr >= 16 && addr < 16 + 3 * (1 + NL)) return 5 + addr - 16;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input int addr);
        int idx;
        idx = model_idx(addr);
        if (idx >= 0) return m_shadow[idx];
        if (addr == 12) return m_fc % 65536;
        if (addr == 13) return {31'h0, m_irqen};
        if (addr == 14) return {29'h0, m_irqs, m_pending, m_busy};
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSH; i++) begin
            m_shadow[i] = (i == 0) ? DEFAULT_BUFFER : 32'h0;
            m_active[i] = m_shadow[i];
        end
        m_busy = 0; m_pending = 0; m_irqs = 0; m_irqen = 0; m_start = 0; m_fc = 0;
    endtask

    task automatic model_clock(input bit rst, input bit wr, input int addr,
                               input logic [31:0] d, input logic [3:0] be, input bit done);
        bit req, clr, start, fin;
        int idx;
        if (rst) begin
            model_reset();
            return;
        end
        req   = wr && addr == 15 && be != 0 && d != 0;
        clr   = wr && be != 0 && ((addr == 15 && d == 0) || (addr == 14 && d[2]));
        fin   = done && m_busy;
        start = 0;
        if (!m_busy) begin
            if (req) begin m_active = m_shadow; m_busy = 1; start = 1; end
        end else if (done) begin
            m_fc = (m_fc + 1) % 65536;
            if (m_pending || req) begin m_active = m_shadow; start = 1; m_pending = 0; end
            else m_busy = 0;
        end else if (req) begin
            m_pending = 1;
        end
        if (fin) m_irqs = 1;
        else if (clr) m_irqs = 0;
        idx = model_idx(addr);
        if (wr && idx >= 0)
            for (int b = 0; b < 4; b++)
                if (be[b]) m_shadow[idx][8*b +: 8] = d[8*b +: 8];
        if (wr && addr == 13 && be[0]) m_irqen = d[0];
        m_start = start;
    endtask

    // One bus cycle: drive, check at the falling edge, advance model at the
    // rising edge.
    task automatic step(input bit rst, input bit wr, input int addr,
                        input logic [31:0] d, input logic [3:0] be, input bit done);
        reset         = rst;
        s1_write      = wr;
        s1_read       = !wr;
        s1_address    = 8'(addr);
        s1_writedata  = d;
        s1_byteenable = be;
        render_done   = done;
        @(negedge clock);
        check_eq("readdata", s1_readdata, model_read(addr));
        check_eq("irq", {31'h0, irq}, {31'h0, m_irqs & m_irqen});
        check_eq("render_start", {31'h0, render_start}, {31'h0, m_start});
        check_eq("start_gap", {31'h0, prev_start & render_start}, 32'h0);
        check_eq("waitrequest", {31'h0, s1_waitrequest}, 32'h0);
        check_eq("cfg_pixel", cfg_pixel_buffer, m_active[0]);
        check_eq("cfg_vbuf", cfg_voxel_buffer, m_active[1]);
        check_eq("cfg_vcount", cfg_voxel_count, m_active[2]);
        check_eq("cfg_pbuf", cfg_palette_buffer, m_active[3]);
        check_eq("cfg_plen", cfg_palette_length, m_active[4]);
        check_eq("cam_pos_x", cfg_cam[0].x, m_active[5]);
        check_eq("cam_look1_y", cfg_cam[2].y, m_active[5 + 3*2 + 1]);
        check_eq("cam_lastlook_z", cfg_cam[NL].z, m_active[5 + 3*NL + 2]);
        l_rdata = s1_readdata; l_vc = cfg_voxel_count; l_vb = cfg_voxel_buffer;
        l_start = render_start; l_irq = irq;
        prev_start = render_start;
        @(posedge clock);
        model_clock(rst, wr, addr, d, be, done);
        #1;
    endtask

    initial begin
        int addr, sel;
        bit rst, wr, done;
        logic [31:0] d;
        logic [3:0] be;

        model_reset();
        reset = 1; s1_write = 0; s1_read = 0; s1_address = 0;
        s1_writedata = 0; s1_byteenable = 0; render_done = 0;
        @(posedge clock); #1;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rst_pixel", l_rdata, DEFAULT_BUFFER);
        step(0, 0, 14, 0, 0, 0);
        check_eq("rst_status", l_rdata, 32'h0);
        check_eq("rst_irq", {31'h0, l_irq}, 32'h0);
        check_eq("rst_start", {31'h0, l_start}, 32'h0);

        // Byte-enabled write; active bank untouched
        step(0, 1, 1, 32'h1234_5678, 4'b0011, 0);
        step(0, 0, 1, 0, 0, 0);
        check_eq("be_write", l_rdata, 32'h0000_5678);
        check_eq("be_active", l_vb, 32'h0);

        // First render from IDLE
        step(0, 1, 2, 32'd100, 4'hF, 0);
        step(0, 1, 15, 32'd1, 4'hF, 0);
        step(0, 0, 14, 0, 0, 0);
        check_eq("start1", {31'h0, l_start}, 32'h1);
        check_eq("vcount1", l_vc, 32'd100);
        check_eq("status_busy", l_rdata, 32'h1);

        // Queued request while busy, then chain on done
        step(0, 1, 2, 32'd200, 4'hF, 0);
        step(0, 1, 15, 32'd1, 4'hF, 0);
        step(0, 0, 14, 0, 0, 0);
        check_eq("status_pend", l_rdata, 32'h3);
        check_eq("vcount_hold", l_vc, 32'd100);
        step(0, 0, 12, 0, 0, 1);
        step(0, 0, 12, 0, 0, 0);
        check_eq("start_chain", {31'h0, l_start}, 32'h1);
        check_eq("vcount2", l_vc, 32'd200);
        check_eq("fcount1", l_rdata, 32'd1);
        step(0, 0, 14, 0, 0, 0);
        check_eq("status_irq", l_rdata, 32'h5);

        // Interrupt enable, W1C, set-wins collision
        step(0, 1, 13, 32'h1, 4'h1, 0);
        step(0, 0, 13, 0, 0, 0);
        check_eq("irq_on", {31'h0, l_irq}, 32'h1);
        step(0, 1, 14, 32'h4, 4'h1, 0);
        step(0, 0, 14, 0, 0, 0);
        check_eq("irq_w1c", {31'h0, l_irq}, 32'h0);
        step(0, 1, 15, 32'h0, 4'hF, 1);
        step(0, 0, 14, 0, 0, 0);
        check_eq("irq_setwins", l_rdata, 32'h4);

        // Reset mid-render with a queued request
        step(0, 1, 15, 32'h1, 4'hF, 0);
        step(0, 1, 15, 32'h1, 4'hF, 0);
        step(1, 0, 14, 0, 0, 0);
        step(0, 0, 14, 0, 0, 0);
        check_eq("midrst_status", l_rdata, 32'h0);
        step(0, 0, 12, 0, 0, 0);
        check_eq("midrst_fc", l_rdata, 32'h0);
        step(0, 0, 12, 0, 0, 1);
        step(0, 0, 12, 0, 0, 0);
        check_eq("idle_done_fc", l_rdata, 32'h0);
        check_eq("midrst_nostart", {31'h0, l_start}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            wr  = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 9);
            if (sel < 2)       addr = 15;
            else if (sel == 2) addr = 14;
            else if (sel == 3) addr = 13;
            else               addr = $urandom_range(0, 40);
            d = $urandom;
            if (addr == 15 && $urandom_range(0, 2) == 0) d = 32'h0;
            be   = 4'($urandom_range(0, 15));
            done = m_busy && !m_start && ($urandom_range(0, 5) == 0);
            step(rst, wr, addr, d, be, done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpu_csr_bank.md
Name: gpu_csr_bank

Overview:
Parametrised Avalon-MM control/status register bank for the voxel GPU. It replaces the flat register front-end with shadow/active register banks, so software can program the next frame while the current frame renders. It adds a render FSM with one queued request, a maskable write-1-to-clear interrupt and a frame counter. It sits between the HPS-facing s1 slave and gpu_controller, and drives the snapshotted configuration plus a render_start pulse.

Parameters:
NUM_LOOK, 4, number of camera look vectors; the camera occupies 3*(1+NUM_LOOK) words from 0x10 (default 0x10..0x1E).
ADDR_WIDTH, 8, s1 word-address width.
FRAME_CNT_WIDTH, 16, width of the frame counter; it is zero-extended on read.
DEFAULT_PIXEL_BUFFER, gpu::DEFAULT_BUFFER, reset value of PIXEL_BUFFER.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
s1_address  in  ADDR_WIDTH  word address
s1_read  in  1  read strobe
s1_readdata  out  32  read data, combinational from s1_address
s1_write  in  1  write strobe
s1_writedata  in  32  write data
s1_byteenable  in  4  per-byte write enables
s1_waitrequest  out  1  tied 0
irq  out  1  irq_status AND irq_enable
render_start  out  1  one-cycle pulse to gpu_controller
render_done  in  1  one-cycle pulse from gpu_controller
cfg_pixel_buffer, cfg_voxel_buffer, cfg_voxel_count, cfg_palette_buffer, cfg_palette_length  out  32 each  active bank
cfg_cam  out  gpu::camera_t (NUM_LOOK)  active camera

Behaviour:
- Register map (word addresses):
  - 0x00 PIXEL_BUFFER, 0x01 VOXEL_BUFFER, 0x02 VOXEL_COUNT, 0x03 PALETTE_BUFFER, 0x04 PALETTE_LENGTH; shadow registers, R/W.
  - 0x0C FRAME_COUNT, read-only.
  - 0x0D IRQ_ENABLE, bit0, R/W.
  - 0x0E STATUS: bit0 busy, bit1 pending, bit2 irq_status (RO except W1C on bit2).
  - 0x0F CONTROL: write nonzero = render request; write 0 = clear irq_status. Reads return 0.
  - 0x10+3k+{0,1,2}: camera word k, components x/y/z (k=0 pos, k=1..NUM_LOOK look0..). Shadow registers, R/W.
- Writes honour s1_byteenable per byte on shadow/RW registers. CONTROL and STATUS act when any byteenable bit is set.
- Unmapped reads return 0; unmapped writes are ignored. Reads return shadow (not active) values.
- Reset values:
  - all shadow and active registers 0, except PIXEL_BUFFER (shadow and active) = DEFAULT_PIXEL_BUFFER;
  - irq_enable 0, irq_status 0, pending 0, frame count 0;
  - state IDLE, render_start 0, irq 0.
- FSM states: IDLE and BUSY.
  - IDLE, render request in cycle N: active <= shadow at end of N; render_start=1 during N+1; state BUSY from N+1.
  - BUSY, render request: pending <= 1. A second request while pending is dropped (depth-1 queue).
  - BUSY, render_done in cycle M:
    - frame_count+1 at M+1, wrapping at 2^FRAME_CNT_WIDTH;
    - irq_status <= 1 at M+1;
    - if pending (or a request arrives in M): snapshot at end of M, render_start at M+1, pending <= 0, stay BUSY;
    - else IDLE at M+1.
  - render_done in IDLE is ignored; it does not change the counter or irq_status.
- Simultaneous events:
  - irq set (render_done) and clear (write 0x0F=0 or W1C) in the same cycle: set wins.
  - Shadow write in the snapshot cycle: the active bank gets the old shadow value; the shadow gets the new value.
- render_start never asserts on consecutive cycles. Active registers change only at snapshot edges.
- Reset mid-render: all state returns to reset values on the next edge, and no render_start is issued. gpu_controller shares the same reset.
- irq is registered-path only, computed combinationally from flops (irq_status AND irq_enable); no glitch from s1.

Decomposition:
- gpu package: camera_t parametrised by NUM_LOOK (vec3 pos plus look array), vec3 typedef, register-address localparams (REG_PIXEL_BUFFER..REG_CONTROL, REG_CAM_BASE=8'h10), STATUS bit indices, DEFAULT_BUFFER.
- One natural sub-module: gpu_csr_reg, a 32-bit byte-enabled register with reset-value parameter, instantiated per shadow word.
- The FSM and interrupt logic stay in gpu_csr_bank.

Test Plan:
- Reset, then read 0x00 -> DEFAULT_PIXEL_BUFFER; read 0x0E -> 0; irq=0; render_start=0.
- Write 0x01=0x1234_5678 with byteenable=4'b0011, then read 0x01 -> 0x0000_5678; cfg_voxel_buffer stays 0.
- Write 0x02=100, then write 0x0F=1 -> render_start high exactly one cycle later; cfg_voxel_count=100; STATUS=0x1.
- While BUSY: write 0x02=200, then 0x0F=1 -> STATUS=0x3; cfg_voxel_count stays 100. Pulse render_done -> next cycle render_start=1, cfg_voxel_count=200, FRAME_COUNT=1, STATUS=0x5.
- IRQ_ENABLE=1 after one frame -> irq=1. Write 0x0E=0x4 -> irq=0. Then render_done coincident with write 0x0F=0 -> irq_status stays 1.
- Assert reset mid-BUSY with pending=1 -> next cycle STATUS=0, FRAME_COUNT=0, no render_start afterwards; render_done in IDLE -> FRAME_COUNT stays 0.
